// File: rtl/uart_rx_os16_if.sv
// Received-byte bundle of uart_rx_os16: byte, completion strobe, error flags and busy.
// The master modport belongs to the receiver; the slave modport belongs to the byte consumer.
interface uart_rx_os16_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (output rx_data, rx_done, frame_err, parity_err, busy);
  modport slave  (input  rx_data, rx_done, frame_err, parity_err, busy);
endinterface

// File: rtl/uart_rx_os16.sv
// 16x-oversampled UART receiver (8N1). It samples each bit at its midpoint and holds a low line in BREAK.
// Define UART_RX_PARITY_EN to receive 8E1 frames and drive a live parity_err.
module uart_rx_os16 #(
  parameter int OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           baud_tick16,
  input  logic           rx,
  uart_rx_os16_if.master rx_out
);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t     state_reg;
  logic [1:0] sync_reg;
  logic [3:0] tick_cnt_reg;
  logic [2:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic [7:0] data_reg;
  logic       done_reg;
  logic       frame_err_reg;
  logic       busy_reg;
`ifdef UART_RX_PARITY_EN
  logic       par_bad_reg;
  logic       parity_err_reg;
`endif
  logic       rx_s;

  // Both stages reset to 1 so that reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  assign rx_s = sync_reg[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      tick_cnt_reg   <= 4'd0;
      bit_cnt_reg    <= 3'd0;
      shift_reg      <= 8'h00;
      data_reg       <= 8'h00;
      done_reg       <= 1'b0;
      frame_err_reg  <= 1'b0;
      busy_reg       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (baud_tick16) begin
        case (state_reg)
          S_IDLE: begin
            if (!rx_s) begin
              state_reg    <= S_START;
              tick_cnt_reg <= 4'd0;
              busy_reg     <= 1'b1;
            end
          end
          S_START: begin
            if (tick_cnt_reg != MID_TICK) begin
              tick_cnt_reg <= tick_cnt_reg + 4'd1;
            end else if (!rx_s) begin
              tick_cnt_reg <= 4'd0;
              bit_cnt_reg  <= 3'd0;
              state_reg    <= S_DATA;
            end else begin
              // Glitch shorter than half a bit: drop it without touching outputs.
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end
          end
          S_DATA: begin
            if (tick_cnt_reg != LAST_TICK) begin
              tick_cnt_reg <= tick_cnt_reg + 4'd1;
            end else begin
              tick_cnt_reg <= 4'd0;
              shift_reg    <= {rx_s, shift_reg[7:1]};
              bit_cnt_reg  <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_reg <= S_PARITY;
`else
                state_reg <= S_STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          S_PARITY: begin
            if (tick_cnt_reg != LAST_TICK) begin
              tick_cnt_reg <= tick_cnt_reg + 4'd1;
            end else begin
              tick_cnt_reg <= 4'd0;
              par_bad_reg  <= rx_s ^ (^shift_reg);
              state_reg    <= S_STOP;
            end
          end
`endif
          S_STOP: begin
            if (tick_cnt_reg != LAST_TICK) begin
              tick_cnt_reg <= tick_cnt_reg + 4'd1;
            end else begin
              tick_cnt_reg   <= 4'd0;
              data_reg       <= shift_reg;
              frame_err_reg  <= ~rx_s;
              done_reg       <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_reg <= par_bad_reg;
`endif
              // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
              if (rx_s) begin
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
              end else begin
                state_reg <= S_BREAK;
              end
            end
          end
          S_BREAK: begin
            if (rx_s) begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end
          end
          default: begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_out.rx_data    = data_reg;
  assign rx_out.rx_done    = done_reg;
  assign rx_out.frame_err  = frame_err_reg;
  assign rx_out.busy       = busy_reg;
`ifdef UART_RX_PARITY_EN
  assign rx_out.parity_err = parity_err_reg;
`else
  assign rx_out.parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

Asynchronous serial receiver, the downstream counterpart of the fixed-pattern UART transmitter: it consumes the serial line produced by the TX stage and recovers 8N1 bytes. It samples the line with a 16x oversampling tick supplied by an external baud tick generator configured for `BAUD*16`. Each completed frame is presented as a byte plus status flags with a one-cycle done strobe, for a byte consumer such as a FIFO or a loopback checker.

## Interface
- `OVERSAMPLE`, 16: ticks per bit. Only the value 16 is supported; the sample points below assume it.
- `clk` input 1: system clock, 100 MHz.
- `rst` input 1: reset, asynchronous, active-low.
- `baud_tick16` input 1: single-`clk`-wide pulse at 16 × baud rate.
- `rx` input 1: serial line; idle high; asynchronous to `clk`.
- `rx_data` output 8: last received byte, LSB first on the line; held until the next `rx_done`.
- `rx_done` output 1: one-`clk` pulse when a frame completes.
- `frame_err` output 1: stop bit sampled 0 on the last frame; updated with `rx_done`.
- `parity_err` output 1: parity mismatch on the last frame; constant 0 without `UART_RX_PARITY_EN`.
- `busy` output 1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer; both flops reset to 1. All decisions below use the synchronized value, `rx_s`.
- Bit counter: 3 bits. Tick counter: 4 bits. Data shift register: 8 bits, shifting right with new bit into bit 7.
- State changes and sampling happen only on `clk` edges where `baud_tick16`=1.
- **IDLE**
  - On a tick with `rx_s`=0: enter START and clear the tick counter.
- **START**
  - At each tick, if the tick counter ≠ 7, increment it.
  - When the tick counter = 7 and `rx_s`=0: this is mid-start. Clear the tick counter and the bit counter, then enter DATA.
  - When the tick counter = 7 and `rx_s`=1: false start. Return to IDLE with no output change.
- **DATA**
  - At each tick, if the tick counter ≠ 15, increment it.
  - When the tick counter = 15: sample `rx_s` into the shift register and clear the tick counter.
  - After the 8th sample (bit counter = 7), go to PARITY if `UART_RX_PARITY_EN` is defined, otherwise to STOP.
- **PARITY** (only with the macro)
  - Same 16-tick sample timing as DATA.
  - Compare the sampled bit with the XOR of the 8 data bits (even parity) and latch the mismatch internally.
  - Then go to STOP.
- **STOP**
  - Same 16-tick sample timing.
  - On the sample: load `rx_data` from the shift register, load `frame_err` = NOT `rx_s`, load `parity_err`, and pulse `rx_done`.
  - If `rx_s`=1, go to IDLE. Ending at mid-stop allows back-to-back frames.
  - If `rx_s`=0, go to BREAK.
- **BREAK**
  - Wait for a tick with `rx_s`=1, then go to IDLE.
  - No new start is detected while the line is held low.
- Reset mid-frame: all state is abandoned; the next falling edge after release starts a fresh frame.

## Timing
- Reset values:
  - Outputs: `rx_data`=0x00, `rx_done`=0, `frame_err`=0, `parity_err`=0, `busy`=0.
  - Internal: state IDLE, counters 0, synchronizer flops 1.
- Synchronizer latency: 2 `clk` from an `rx` edge to `rx_s`.
- Sample points, with t0 = the tick on which IDLE sees `rx_s`=0:
  - Start bit: tick t0+8.
  - Data bit i (i = 0..7): tick t0+24+16i.
  - Parity bit: tick t0+152.
  - Stop bit: tick t0+152 without parity, t0+168 with parity.
- `rx_done`, `rx_data`, `frame_err` and `parity_err` are registered on the stop-sample tick edge, so they are visible on the following cycle.
- `rx_done` is high for exactly 1 `clk`.
- `busy` goes high the cycle after t0 and low the cycle after leaving STOP or BREAK.
- `baud_tick16` arriving in the same cycle as reset release is ignored.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Frame is 8E1: PARITY state is present and `parity_err` is live.
- Not defined:
  - Frame is 8N1: PARITY state is absent and `parity_err` is tied to 0.

## Test plan
Bench setup: tick every 651 `clk`; bit period = 16 ticks.

- Frame 0x30, 8N1 → `rx_data`=0x30, one `rx_done` pulse at tick t0+152, `frame_err`=0, `busy` back to 0.
- Back-to-back 0x55 then 0xA3 with no idle gap → two `rx_done` pulses 160 ticks apart; `rx_data` reads 0x55 then 0xA3.
- `rx` low for 5 ticks, then high → no `rx_done`; `busy` high for about 8 ticks, then 0; `rx_data` unchanged.
- 0x00 with the line held low for 20 bit times → `rx_done` with `frame_err`=1 and `rx_data`=0x00. No further `rx_done` until the line returns high. A following 0x41 frame is then received with `frame_err`=0.
- `rst`=0 during data bit 3 of 0xFF → all outputs return to their reset values immediately. After release, a 0x7E frame gives `rx_data`=0x7E with one `rx_done`.
- With `UART_RX_PARITY_EN`:
  - 0x31 with parity bit 0 (wrong; correct value is 1) → `parity_err`=1.
  - 0x31 with parity bit 1 → `parity_err`=0.
  - `rx_data`=0x31 in both cases.
